// File: rtl/zap_ram_arbiter_if.sv
// Bus bundle between two RAM clients, the arbiter and a 1R+1W RAM.
// slave: arbiter side (client requests and RAM read data in; grants, read response and RAM controls out); master: the opposite view.
interface zap_ram_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]         i_rd_req;
    logic [2*AW-1:0]    i_rd_addr;
    logic [1:0]         o_rd_gnt;
    logic [1:0]         o_rd_valid;
    logic [WIDTH-1:0]   o_rd_data;

    logic [1:0]         i_wr_req;
    logic [2*AW-1:0]    i_wr_addr;
    logic [2*WIDTH-1:0] i_wr_data;
    logic [1:0]         o_wr_gnt;

    logic               o_ram_rd_en;
    logic [AW-1:0]      o_ram_rd_addr;
    logic               o_ram_wr_en;
    logic [AW-1:0]      o_ram_wr_addr;
    logic [WIDTH-1:0]   o_ram_wr_data;
    logic [WIDTH-1:0]   i_ram_rd_data;

    logic               o_init_done;

    modport slave (
        input  i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data,
        input  i_ram_rd_data,
        output o_rd_gnt, o_rd_valid, o_rd_data, o_wr_gnt,
        output o_ram_rd_en, o_ram_rd_addr,
        output o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data,
        output o_init_done
    );

    modport master (
        output i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data,
        output i_ram_rd_data,
        input  o_rd_gnt, o_rd_valid, o_rd_data, o_wr_gnt,
        input  o_ram_rd_en, o_ram_rd_addr,
        input  o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data,
        input  o_init_done
    );
endinterface

// File: rtl/zap_ram_arbiter.sv
// Two-client round-robin arbiter for a 1R+1W RAM with post-reset zero scrub.
// Ports: i_clk, i_reset_n (sync, active-low), bus (zap_ram_arbiter_if.slave). Optional ZAP_RAM_ARB_FWD_EN: write-to-read forwarding on same-address collisions.
module zap_ram_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    zap_ram_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        SCRUB,
        RUN
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] scrub_cnt, scrub_cnt_nx;
    logic          rd_ptr, wr_ptr;
    logic [1:0]    rd_gnt, wr_gnt;
    logic [1:0]    rd_valid;
    logic          init_done;

    // ptr names the client that wins when both request.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
        logic [1:0] g;
        unique case (req)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = ptr ? 2'b10 : 2'b01;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state     <= SCRUB;
            scrub_cnt <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_valid  <= 2'b00;
            init_done <= 1'b0;
        end else begin
            state     <= state_nx;
            scrub_cnt <= scrub_cnt_nx;
            // After a grant the other client gets priority.
            if (|rd_gnt) rd_ptr <= rd_gnt[0];
            if (|wr_gnt) wr_ptr <= wr_gnt[0];
            rd_valid  <= rd_gnt;
            init_done <= (state_nx == RUN);
        end
    end

    always_comb begin
        state_nx          = state;
        scrub_cnt_nx      = scrub_cnt;
        rd_gnt            = 2'b00;
        wr_gnt            = 2'b00;
        bus.o_ram_rd_en   = 1'b0;
        bus.o_ram_rd_addr = '0;
        bus.o_ram_wr_en   = 1'b0;
        bus.o_ram_wr_addr = '0;
        bus.o_ram_wr_data = '0;
        unique case (state)
            SCRUB: begin
                bus.o_ram_wr_en   = 1'b1;
                bus.o_ram_wr_addr = scrub_cnt;
                // Wraps back to 0 after the last entry (DEPTH is a power of two).
                scrub_cnt_nx      = scrub_cnt + AW'(1);
                if (scrub_cnt == AW'(DEPTH - 1)) state_nx = RUN;
            end
            RUN: begin
                rd_gnt            = rr_pick(bus.i_rd_req, rd_ptr);
                wr_gnt            = rr_pick(bus.i_wr_req, wr_ptr);
                bus.o_ram_rd_en   = |rd_gnt;
                bus.o_ram_rd_addr = rd_gnt[1] ? bus.i_rd_addr[AW +: AW]
                                              : bus.i_rd_addr[0 +: AW];
                bus.o_ram_wr_en   = |wr_gnt;
                bus.o_ram_wr_addr = wr_gnt[1] ? bus.i_wr_addr[AW +: AW]
                                              : bus.i_wr_addr[0 +: AW];
                bus.o_ram_wr_data = wr_gnt[1] ? bus.i_wr_data[WIDTH +: WIDTH]
                                              : bus.i_wr_data[0 +: WIDTH];
            end
            default: state_nx = SCRUB;
        endcase
    end

    assign bus.o_rd_gnt    = rd_gnt;
    assign bus.o_wr_gnt    = wr_gnt;
    assign bus.o_rd_valid  = rd_valid;
    assign bus.o_init_done = init_done;

`ifdef ZAP_RAM_ARB_FWD_EN
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_data;

    // The RAM returns pre-write data on a collision, so remember the write.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd_hit  <= bus.o_ram_rd_en && bus.o_ram_wr_en &&
                        (bus.o_ram_rd_addr == bus.o_ram_wr_addr);
            fwd_data <= bus.o_ram_wr_data;
        end
    end

    assign bus.o_rd_data = !(|rd_valid) ? '0 :
                           fwd_hit      ? fwd_data : bus.i_ram_rd_data;
`else
    // Zero when no response is pending, so reset holds it at 0.
    assign bus.o_rd_data = (|rd_valid) ? bus.i_ram_rd_data : '0;
`endif

endmodule

// File: tb/tb_zap_ram_arbiter.sv
// Directed self-checking bench for zap_ram_arbiter (WIDTH=32, DEPTH=32).
// Models a registered 1R+1W RAM behind the arbiter; inputs change on negedge, outputs sampled 1 ns later.
module tb_zap_ram_arbiter;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;

`ifdef ZAP_RAM_ARB_FWD_EN
    localparam logic [31:0] FWD_EXP = 32'hDEADBEEF;
`else
    localparam logic [31:0] FWD_EXP = 32'h0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    zap_ram_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    zap_ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.o_ram_rd_en) bus.i_ram_rd_data <= mem[bus.o_ram_rd_addr];
        if (bus.o_ram_wr_en) mem[bus.o_ram_wr_addr] <= bus.o_ram_wr_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.i_rd_req  = 2'b11;
        bus.i_rd_addr = '0;
        bus.i_wr_req  = 2'b11;
        bus.i_wr_addr = '0;
        bus.i_wr_data = '0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (bus.o_rd_valid !== 2'b00) begin n_bad++; $display("FAIL reset rd_valid: got %b want 00", bus.o_rd_valid); end
        n_cmp++; if (bus.o_init_done !== 1'b0) begin n_bad++; $display("FAIL reset init_done: got %b want 0", bus.o_init_done); end
        n_cmp++; if (bus.o_rd_data !== 32'h0) begin n_bad++; $display("FAIL reset rd_data: got %h want 0", bus.o_rd_data); end
        n_cmp++; if (bus.o_rd_gnt !== 2'b00) begin n_bad++; $display("FAIL reset rd_gnt: got %b want 00", bus.o_rd_gnt); end
        n_cmp++; if (bus.o_wr_gnt !== 2'b00) begin n_bad++; $display("FAIL reset wr_gnt: got %b want 00", bus.o_wr_gnt); end
        n_cmp++; if (bus.o_ram_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset ram_rd_en: got %b want 0", bus.o_ram_rd_en); end
    endtask

    task automatic test_scrub();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            n_cmp++; if (bus.o_ram_wr_en !== 1'b1) begin n_bad++; $display("FAIL scrub wr_en[%0d]: got %b want 1", k, bus.o_ram_wr_en); end
            n_cmp++; if (bus.o_ram_wr_addr !== 5'(k)) begin n_bad++; $display("FAIL scrub wr_addr[%0d]: got %0d want %0d", k, bus.o_ram_wr_addr, k); end
            n_cmp++; if (bus.o_ram_wr_data !== 32'h0) begin n_bad++; $display("FAIL scrub wr_data[%0d]: got %h want 0", k, bus.o_ram_wr_data); end
            n_cmp++; if (bus.o_rd_gnt !== 2'b00 || bus.o_wr_gnt !== 2'b00) begin n_bad++; $display("FAIL scrub gnt[%0d]: got rd %b wr %b want 00 00", k, bus.o_rd_gnt, bus.o_wr_gnt); end
            n_cmp++; if (bus.o_ram_rd_en !== 1'b0) begin n_bad++; $display("FAIL scrub rd_en[%0d]: got %b want 0", k, bus.o_ram_rd_en); end
            n_cmp++; if (bus.o_init_done !== 1'b0) begin n_bad++; $display("FAIL scrub init_done[%0d]: got %b want 0", k, bus.o_init_done); end
            if (k == DEPTH - 1) begin
                bus.i_rd_req = 2'b00;
                bus.i_wr_req = 2'b00;
            end
            @(negedge clk);
            #1;
        end
        n_cmp++; if (bus.o_init_done !== 1'b1) begin n_bad++; $display("FAIL scrub done init_done: got %b want 1", bus.o_init_done); end
        n_cmp++; if (bus.o_ram_wr_en !== 1'b0) begin n_bad++; $display("FAIL idle wr_en: got %b want 0", bus.o_ram_wr_en); end
        n_cmp++; if (bus.o_ram_rd_en !== 1'b0) begin n_bad++; $display("FAIL idle rd_en: got %b want 0", bus.o_ram_rd_en); end
    endtask

    task automatic test_write_single();
        @(negedge clk);
        bus.i_wr_req  = 2'b01;
        bus.i_wr_addr = {5'd0, 5'd3};
        bus.i_wr_data = {32'h0, 32'h33};
        #1;
        n_cmp++; if (bus.o_wr_gnt !== 2'b01) begin n_bad++; $display("FAIL wr0 gnt: got %b want 01", bus.o_wr_gnt); end
        n_cmp++; if (bus.o_ram_wr_en !== 1'b1 || bus.o_ram_wr_addr !== 5'd3 || bus.o_ram_wr_data !== 32'h33) begin n_bad++; $display("FAIL wr0 port: got en %b a %0d d %h want 1 3 33", bus.o_ram_wr_en, bus.o_ram_wr_addr, bus.o_ram_wr_data); end
        @(negedge clk);
        bus.i_wr_req  = 2'b10;
        bus.i_wr_addr = {5'd7, 5'd0};
        bus.i_wr_data = {32'h77, 32'h0};
        #1;
        n_cmp++; if (bus.o_wr_gnt !== 2'b10) begin n_bad++; $display("FAIL wr1 gnt: got %b want 10", bus.o_wr_gnt); end
        n_cmp++; if (bus.o_ram_wr_addr !== 5'd7 || bus.o_ram_wr_data !== 32'h77) begin n_bad++; $display("FAIL wr1 port: got a %0d d %h want 7 77", bus.o_ram_wr_addr, bus.o_ram_wr_data); end
        @(negedge clk);
        bus.i_wr_req = 2'b00;
        #1;
        n_cmp++; if (bus.o_ram_wr_en !== 1'b0 || bus.o_wr_gnt !== 2'b00) begin n_bad++; $display("FAIL wr idle: got en %b gnt %b want 0 00", bus.o_ram_wr_en, bus.o_wr_gnt); end
    endtask

    task automatic test_read_rr();
        logic [1:0]  eg [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [4:0]  ea [4] = '{5'd3, 5'd7, 5'd3, 5'd7};
        logic [31:0] ed [4] = '{32'h0, 32'h33, 32'h77, 32'h33};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.i_rd_req  = 2'b11;
            bus.i_rd_addr = {5'd7, 5'd3};
            #1;
            n_cmp++; if (bus.o_rd_gnt !== eg[i]) begin n_bad++; $display("FAIL rr gnt[%0d]: got %b want %b", i, bus.o_rd_gnt, eg[i]); end
            n_cmp++; if (bus.o_ram_rd_en !== 1'b1 || bus.o_ram_rd_addr !== ea[i]) begin n_bad++; $display("FAIL rr port[%0d]: got en %b a %0d want 1 %0d", i, bus.o_ram_rd_en, bus.o_ram_rd_addr, ea[i]); end
            if (i > 0) begin
                n_cmp++; if (bus.o_rd_valid !== eg[i-1] || bus.o_rd_data !== ed[i]) begin n_bad++; $display("FAIL rr resp[%0d]: got v %b d %h want %b %h", i, bus.o_rd_valid, bus.o_rd_data, eg[i-1], ed[i]); end
            end
        end
        @(negedge clk);
        bus.i_rd_req = 2'b00;
        #1;
        n_cmp++; if (bus.o_rd_gnt !== 2'b00 || bus.o_ram_rd_en !== 1'b0) begin n_bad++; $display("FAIL rr idle: got gnt %b en %b want 00 0", bus.o_rd_gnt, bus.o_ram_rd_en); end
        n_cmp++; if (bus.o_rd_valid !== 2'b10 || bus.o_rd_data !== 32'h77) begin n_bad++; $display("FAIL rr last: got v %b d %h want 10 77", bus.o_rd_valid, bus.o_rd_data); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.o_rd_valid !== 2'b00 || bus.o_rd_data !== 32'h0) begin n_bad++; $display("FAIL rr drain: got v %b d %h want 00 0", bus.o_rd_valid, bus.o_rd_data); end
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        bus.i_rd_req  = 2'b01;
        bus.i_rd_addr = {5'd0, 5'd5};
        bus.i_wr_req  = 2'b10;
        bus.i_wr_addr = {5'd5, 5'd0};
        bus.i_wr_data = {32'hDEADBEEF, 32'h0};
        #1;
        n_cmp++; if (bus.o_rd_gnt !== 2'b01 || bus.o_wr_gnt !== 2'b10) begin n_bad++; $display("FAIL coll gnt: got rd %b wr %b want 01 10", bus.o_rd_gnt, bus.o_wr_gnt); end
        n_cmp++; if (bus.o_ram_rd_addr !== 5'd5 || bus.o_ram_wr_addr !== 5'd5 || bus.o_ram_wr_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL coll port: got ra %0d wa %0d d %h want 5 5 deadbeef", bus.o_ram_rd_addr, bus.o_ram_wr_addr, bus.o_ram_wr_data); end
        @(negedge clk);
        bus.i_rd_req = 2'b00;
        bus.i_wr_req = 2'b00;
        #1;
        n_cmp++; if (bus.o_rd_valid !== 2'b01 || bus.o_rd_data !== FWD_EXP) begin n_bad++; $display("FAIL coll resp: got v %b d %h want 01 %h", bus.o_rd_valid, bus.o_rd_data, FWD_EXP); end
        @(negedge clk);
        bus.i_rd_req = 2'b01;
        #1;
        n_cmp++; if (bus.o_rd_gnt !== 2'b01) begin n_bad++; $display("FAIL reread gnt: got %b want 01", bus.o_rd_gnt); end
        @(negedge clk);
        bus.i_rd_req = 2'b00;
        #1;
        n_cmp++; if (bus.o_rd_valid !== 2'b01 || bus.o_rd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL reread resp: got v %b d %h want 01 deadbeef", bus.o_rd_valid, bus.o_rd_data); end
    endtask

    task automatic test_write_contention();
        @(negedge clk);
        bus.i_wr_req  = 2'b11;
        bus.i_wr_addr = {5'd9, 5'd9};
        bus.i_wr_data = {32'h22, 32'h11};
        #1;
        n_cmp++; if (bus.o_wr_gnt !== 2'b01 || bus.o_ram_wr_data !== 32'h11) begin n_bad++; $display("FAIL wcont first: got gnt %b d %h want 01 11", bus.o_wr_gnt, bus.o_ram_wr_data); end
        @(negedge clk);
        bus.i_wr_req = 2'b10;
        #1;
        n_cmp++; if (bus.o_wr_gnt !== 2'b10 || bus.o_ram_wr_data !== 32'h22 || bus.o_ram_wr_addr !== 5'd9) begin n_bad++; $display("FAIL wcont second: got gnt %b a %0d d %h want 10 9 22", bus.o_wr_gnt, bus.o_ram_wr_addr, bus.o_ram_wr_data); end
        @(negedge clk);
        bus.i_wr_req  = 2'b00;
        bus.i_rd_req  = 2'b10;
        bus.i_rd_addr = {5'd9, 5'd0};
        #1;
        n_cmp++; if (bus.o_rd_gnt !== 2'b10 || bus.o_ram_rd_addr !== 5'd9) begin n_bad++; $display("FAIL wcont rd gnt: got %b a %0d want 10 9", bus.o_rd_gnt, bus.o_ram_rd_addr); end
        @(negedge clk);
        bus.i_rd_req = 2'b00;
        #1;
        n_cmp++; if (bus.o_rd_valid !== 2'b10 || bus.o_rd_data !== 32'h22) begin n_bad++; $display("FAIL wcont rd resp: got v %b d %h want 10 22", bus.o_rd_valid, bus.o_rd_data); end
    endtask

    task automatic test_single_client();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.i_rd_req  = 2'b10;
            bus.i_rd_addr = {5'd7, 5'd0};
            #1;
            n_cmp++; if (bus.o_rd_gnt !== 2'b10 || bus.o_ram_rd_addr !== 5'd7) begin n_bad++; $display("FAIL solo gnt[%0d]: got %b a %0d want 10 7", i, bus.o_rd_gnt, bus.o_ram_rd_addr); end
            if (i > 0) begin
                n_cmp++; if (bus.o_rd_valid !== 2'b10 || bus.o_rd_data !== 32'h77) begin n_bad++; $display("FAIL solo resp[%0d]: got v %b d %h want 10 77", i, bus.o_rd_valid, bus.o_rd_data); end
            end
        end
        @(negedge clk);
        bus.i_rd_req  = 2'b11;
        bus.i_rd_addr = {5'd7, 5'd3};
        #1;
        n_cmp++; if (bus.o_rd_gnt !== 2'b01) begin n_bad++; $display("FAIL solo ptr: got %b want 01", bus.o_rd_gnt); end
        @(negedge clk);
        bus.i_rd_req = 2'b10;
        #1;
        n_cmp++; if (bus.o_rd_gnt !== 2'b10 || bus.o_rd_valid !== 2'b01 || bus.o_rd_data !== 32'h33) begin n_bad++; $display("FAIL solo tail: got g %b v %b d %h want 10 01 33", bus.o_rd_gnt, bus.o_rd_valid, bus.o_rd_data); end
        @(negedge clk);
        bus.i_rd_req = 2'b00;
        #1;
        n_cmp++; if (bus.o_rd_valid !== 2'b10 || bus.o_rd_data !== 32'h77) begin n_bad++; $display("FAIL solo last: got v %b d %h want 10 77", bus.o_rd_valid, bus.o_rd_data); end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        bus.i_rd_req  = 2'b01;
        bus.i_rd_addr = {5'd0, 5'd3};
        rst_n         = 1'b0;
        @(negedge clk);
        bus.i_rd_req = 2'b00;
        #1;
        n_cmp++; if (bus.o_rd_valid !== 2'b00 || bus.o_rd_data !== 32'h0) begin n_bad++; $display("FAIL rrst resp: got v %b d %h want 00 0", bus.o_rd_valid, bus.o_rd_data); end
        n_cmp++; if (bus.o_init_done !== 1'b0) begin n_bad++; $display("FAIL rrst init_done: got %b want 0", bus.o_init_done); end
        n_cmp++; if (bus.o_ram_wr_en !== 1'b1 || bus.o_ram_wr_addr !== 5'd0) begin n_bad++; $display("FAIL rrst scrub: got en %b a %0d want 1 0", bus.o_ram_wr_en, bus.o_ram_wr_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            n_cmp++; if (bus.o_ram_wr_en !== 1'b1 || bus.o_ram_wr_addr !== 5'(k)) begin n_bad++; $display("FAIL rescrub[%0d]: got en %b a %0d want 1 %0d", k, bus.o_ram_wr_en, bus.o_ram_wr_addr, k); end
            @(negedge clk);
            #1;
        end
        n_cmp++; if (bus.o_init_done !== 1'b1) begin n_bad++; $display("FAIL rescrub done: got %b want 1", bus.o_init_done); end
        @(negedge clk);
        bus.i_rd_req  = 2'b11;
        bus.i_rd_addr = {5'd7, 5'd3};
        #1;
        n_cmp++; if (bus.o_rd_gnt !== 2'b01) begin n_bad++; $display("FAIL rrst ptr: got %b want 01", bus.o_rd_gnt); end
        @(negedge clk);
        bus.i_rd_req = 2'b00;
        #1;
        n_cmp++; if (bus.o_rd_valid !== 2'b01 || bus.o_rd_data !== 32'h0) begin n_bad++; $display("FAIL rrst wiped: got v %b d %h want 01 0", bus.o_rd_valid, bus.o_rd_data); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_scrub();
        test_write_single();
        test_read_rr();
        test_same_addr();
        test_write_contention();
        test_single_client();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
